fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/offset datapath width.
REQ-002 SHALL have parameter MAX_WAIT, default 15, maximum imem_ready wait cycles before error.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide port clk  input  1  rising-edge clock.
REQ-005 SHALL provide port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port imem_ready  input  1  instruction memory returns an instruction this cycle.
REQ-007 SHALL provide port stall  input  1  decode cannot accept an instruction.
REQ-008 SHALL provide port branch_taken  input  1  execute stage requests PC redirect.
REQ-009 SHALL provide port branch_offset  input  WIDTH  redirect offset, relative to the PC at update time.
REQ-010 SHALL provide port imem_req  output  1  fetch request to instruction memory.
REQ-011 SHALL provide port pc_en  output  1  PC register load enable.
REQ-012 SHALL provide port pcsrc  output  1  PC mux select (1 = PC+immop, 0 = PC+4).
REQ-013 SHALL provide port immop  output  WIDTH  offset driven to the PC branch adder.
REQ-014 SHALL provide port instr_valid  output  1  fetched instruction valid to decode.
REQ-015 SHALL provide port flush  output  1  one-cycle wrong-path squash.
REQ-016 SHALL provide port error  output  1  sticky fetch timeout.

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, HOLD, REDIRECT, ERROR.
REQ-018 BOOT: all outputs 0; next state FETCH unconditionally.
REQ-019 FETCH: imem_req=1; on imem_ready=0, wait counter increments; at count==MAX_WAIT, next state ERROR.
REQ-020 FETCH, imem_ready=1, no branch pending/current, stall=0: instr_valid=1, pc_en=1, pcsrc=0; remain FETCH; clear wait counter.
REQ-021 FETCH, imem_ready=1, stall=1: instr_valid=1, pc_en=0; next state HOLD.
REQ-022 HOLD: imem_req=0, instr_valid=1; stall=0 -> pc_en=1, next state FETCH (or REDIRECT per REQ-025).
REQ-023 branch_taken=1 in any state but BOOT/ERROR SHALL capture branch_offset into a pending register; a later branch_taken before application overwrites it.
REQ-024 At a PC update point (REQ-020/REQ-022), if pending or current branch: pc_en=1, pcsrc=1, immop=offset (current input takes priority over pending), instr_valid=0, flush=1; pending cleared.
REQ-025 After a redirect SHALL enter REDIRECT: one bubble, imem_req=0, instr_valid=0; next state FETCH.
REQ-026 immop SHALL be 0 whenever pcsrc=0.
REQ-027 ERROR: error=1, all other outputs 0; exit only via reset.
REQ-028 pc_en SHALL never assert for more than one cycle per fetched instruction.

Reset
REQ-029 rst=0 SHALL immediately force state BOOT, wait counter 0, pending register cleared, all outputs 0.
REQ-030 Reset asserted mid-FETCH or mid-HOLD SHALL discard the in-flight instruction; no pc_en on reset release cycle.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the FSM state enum and MAX_WAIT default.
REQ-032 Wait counter SHALL be a sub-module wait_timer (clear, enable, terminal-count output).

Verification
REQ-033 Reset release, imem_ready=1, stall=0 for 4 cycles -> BOOT 1 cycle, then pc_en=1, pcsrc=0, instr_valid=1 each cycle.
REQ-034 stall=1 for 3 cycles on returned instruction -> instr_valid held 3 cycles, pc_en=0, imem_req=0; pc_en=1 on stall drop.
REQ-035 branch_taken=1, offset=0x10 with imem_ready=1 -> same cycle pcsrc=1, immop=0x10, flush=1, instr_valid=0; next cycle imem_req=0.
REQ-036 branch_taken offsets 0x20 then 0x40 during imem_ready=0 -> redirect uses immop=0x40.
REQ-037 imem_ready=0 for 15 cycles -> error=1 sticky, imem_req=0 until rst=0.
REQ-038 rst=0 during HOLD -> all outputs 0 asynchronously; BOOT on release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StHold,
        StRedirect,
        StError
    } fetch_state_e;

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive imem miss cycles; tc_o flags the MAX_WAIT-th enabled cycle.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CntW-1:0] count_q;

    assign tc_o = en_i && (count_q == CntW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && !tc_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives imem requests, PC load/select, branch redirects and timeout error.
// Outputs are decoded from the registered state and the current-cycle inputs.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    output logic             imem_req,
    output logic             pc_en,
    output logic             pcsrc,
    output logic [WIDTH-1:0] immop,
    output logic             instr_valid,
    output logic             flush,
    output logic             error
);

    fetch_state_e     state_q;
    logic             pend_q;
    logic [WIDTH-1:0] pend_off_q;

    logic timer_en;
    logic timer_tc;
    logic upd_point;
    logic redirect;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!timer_en),
        .en_i  (timer_en),
        .tc_o  (timer_tc)
    );

    always_comb begin
        timer_en  = (state_q == StFetch) && !imem_ready;
        upd_point = !stall && (((state_q == StFetch) && imem_ready) || (state_q == StHold));
        redirect  = upd_point && (branch_taken || pend_q);
    end

    always_comb begin
        imem_req    = 1'b0;
        pc_en       = 1'b0;
        instr_valid = 1'b0;
        error       = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req    = 1'b1;
                instr_valid = imem_ready && !redirect;
                pc_en       = upd_point;
            end
            StHold: begin
                instr_valid = !redirect;
                pc_en       = upd_point;
            end
            StError: error = 1'b1;
            default: ;
        endcase
        pcsrc = redirect;
        flush = redirect;
        // A branch arriving this cycle wins over the older pending one.
        immop = redirect ? (branch_taken ? branch_offset : pend_off_q) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StBoot;
            pend_q     <= 1'b0;
            pend_off_q <= '0;
        end else begin
            unique case (state_q)
                StBoot:     state_q <= StFetch;
                StFetch: begin
                    if (timer_tc) begin
                        state_q <= StError;
                    end else if (redirect) begin
                        state_q <= StRedirect;
                    end else if (imem_ready && stall) begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        state_q <= StRedirect;
                    end else if (!stall) begin
                        state_q <= StFetch;
                    end
                end
                StRedirect: state_q <= StFetch;
                StError:    state_q <= StError;
                default:    state_q <= StBoot;
            endcase

            if (redirect) begin
                pend_q <= 1'b0;
            end else if (branch_taken && (state_q != StBoot) && (state_q != StError)) begin
                pend_q     <= 1'b1;
                pend_off_q <= branch_offset;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic against a model.
module tb_fetch_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned MW = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         imem_ready = 1'b0;
    logic         stall = 1'b0;
    logic         branch_taken = 1'b0;
    logic [W-1:0] branch_offset = '0;
    logic         imem_req;
    logic         pc_en;
    logic         pcsrc;
    logic [W-1:0] immop;
    logic         instr_valid;
    logic         flush;
    logic         error;

    fetch_ctrl #(
        .WIDTH    (W),
        .MAX_WAIT (MW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .imem_req      (imem_req),
        .pc_en         (pc_en),
        .pcsrc         (pcsrc),
        .immop         (immop),
        .instr_valid   (instr_valid),
        .flush         (flush),
        .error         (error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: booting, dead (timed out), holding an instruction, inserting a bubble.
    bit           m_boot;
    bit           m_err;
    bit           m_hold;
    bit           m_bubble;
    int           m_miss;
    logic [W-1:0] m_pend[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [5:0] flags();
        return {imem_req, pc_en, pcsrc, instr_valid, flush, error};
    endfunction

    task automatic model_reset();
        m_boot   = 1'b1;
        m_err    = 1'b0;
        m_hold   = 1'b0;
        m_bubble = 1'b0;
        m_miss   = 0;
        m_pend.delete();
    endtask

    // flags bit order: req, pc_en, pcsrc, instr_valid, flush, error
    task automatic step(input bit r, input bit s, input bit b, input logic [W-1:0] off,
                        input string tag);
        logic [5:0]   ef;
        logic [W-1:0] eimm;
        bit           rdy;
        @(negedge clk);
        imem_ready    = r;
        stall         = s;
        branch_taken  = b;
        branch_offset = off;
        #1;
        ef   = '0;
        eimm = '0;
        if (m_err) begin
            ef[0] = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
            if (b) m_pend.push_back(off);
        end else begin
            ef[5] = !m_hold;
            rdy   = m_hold || r;
            if (!rdy) begin
                m_miss++;
                if (b) m_pend.push_back(off);
                if (m_miss == int'(MW)) m_err = 1'b1;
            end else begin
                m_miss = 0;
                if (s) begin
                    ef[2] = 1'b1;
                    if (b) m_pend.push_back(off);
                    m_hold = 1'b1;
                end else if (b || m_pend.size() != 0) begin
                    ef[4] = 1'b1;
                    ef[3] = 1'b1;
                    ef[1] = 1'b1;
                    eimm  = b ? off : m_pend[$];
                    m_pend.delete();
                    m_bubble = 1'b1;
                    m_hold   = 1'b0;
                end else begin
                    ef[2]  = 1'b1;
                    ef[4]  = 1'b1;
                    m_hold = 1'b0;
                end
            end
        end
        check_eq({tag, ".flags"}, 64'(flags()), 64'(ef));
        check_eq({tag, ".immop"}, 64'(immop), 64'(eimm));
    endtask

    // Asserts reset mid-cycle with inputs still active, releases just after a rising edge.
    task automatic apply_reset(input bit mid_check);
        #1;
        rst = 1'b0;
        if (mid_check) begin
            #1;
            check_eq("async_rst.flags", 64'(flags()), 64'(0));
            check_eq("async_rst.immop", 64'(immop), 64'(0));
        end
        imem_ready   = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #2;
        check_eq("por.flags", 64'(flags()), 64'(0));
        check_eq("por.immop", 64'(immop), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        repeat (4) step(1'b1, 1'b0, 1'b0, '0, "boot_run");

        repeat (3) step(1'b1, 1'b1, 1'b0, '0, "stall");
        step(1'b1, 1'b0, 1'b0, '0, "stall_drop");

        step(1'b1, 1'b0, 1'b1, 32'h10, "br10");
        step(1'b1, 1'b0, 1'b0, '0, "br10_bubble");
        step(1'b1, 1'b0, 1'b0, '0, "br10_refetch");

        step(1'b0, 1'b0, 1'b1, 32'h20, "pend20");
        step(1'b0, 1'b0, 1'b1, 32'h40, "pend40");
        step(1'b1, 1'b0, 1'b0, '0, "pend_apply");
        step(1'b1, 1'b0, 1'b0, '0, "pend_bubble");

        step(1'b1, 1'b1, 1'b1, 32'h80, "hold_br");
        step(1'b0, 1'b1, 1'b0, '0, "hold_wait");
        step(1'b1, 1'b0, 1'b0, '0, "hold_apply");
        step(1'b1, 1'b0, 1'b0, '0, "hold_bubble");

        step(1'b1, 1'b1, 1'b0, '0, "to_hold");
        step(1'b1, 1'b1, 1'b0, '0, "in_hold");
        apply_reset(1'b1);
        step(1'b1, 1'b0, 1'b0, '0, "post_rst_boot");
        step(1'b1, 1'b0, 1'b0, '0, "post_rst_fetch");

        repeat (MW + 1) step(1'b0, 1'b0, 1'b0, '0, "timeout");
        repeat (3) step(1'b1, 1'b0, 1'b1, 32'h44, "err_sticky");
        apply_reset(1'b0);
        step(1'b1, 1'b0, 1'b0, '0, "err_rst_boot");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(255, 0) == 0) apply_reset(1'b1);
            step(bit'($urandom_range(9, 0) < 8), bit'($urandom_range(9, 0) < 3),
                 bit'($urandom_range(9, 0) < 2), W'($urandom) & 32'h0000_fffc, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
